// File: rtl/jpeg_byte_stuffer.sv
// -----------------------------------------------------------------------------
// jpeg_byte_stuffer
//   Serialises the bit packer's 32-bit MSB-first entropy-coded words into an
//   8-bit byte stream. Each 0xFF data byte is followed by a stuffed 0x00, and
//   an EOI marker (FF D9) can be appended after all accepted data.
//
// Ports
//   clk     in   1      clock
//   rst     in   1      asynchronous, active-low reset
//   ivalid  in   1      idata valid
//   idata   in   32     packed word, idata[31:24] emitted first
//   iready  out  1      word accepted when ivalid && iready
//   ieoi    in   1      request FF D9 after all accepted data (sampled with iready)
//   ovalid  out  1      odata valid
//   odata   out  8      output byte
//   oready  in   1      sink accepts odata when ovalid && oready
//   olast   out  1      high with the D9 byte of an EOI marker
//   nbytes  out  CNT_W  count of output handshakes since reset (wraps)
// -----------------------------------------------------------------------------
module jpeg_byte_stuffer #(
   parameter bit STUFF_EN = 1'b1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ivalid,
   input  logic [31:0]      idata,
   output logic             iready,
   input  logic             ieoi,
   output logic             ovalid,
   output logic [7:0]       odata,
   input  logic             oready,
   output logic             olast,
   output logic [CNT_W-1:0] nbytes
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
      ST_STUFF  = 3'd2,
      ST_EOI_FF = 3'd3,
      ST_EOI_D9 = 3'd4
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   state_t           end_state_s;
   logic [31:0]      wbuf_r;
   logic [31:0]      wbuf_nxt_s;
   logic [1:0]       idx_r;
   logic [1:0]       idx_nxt_s;
   logic             eoi_pend_r;
   logic             eoi_pend_nxt_s;
   logic             eoi_any_s;
   logic             ovalid_r;
   logic [7:0]       odata_r;
   logic             olast_r;
   logic [CNT_W-1:0] nbytes_r;
   logic [7:0]       cur_s;
   logic             hs_s;
   logic             stuff_now_s;
   logic             final_hs_s;
   logic             accept_s;
   logic             eoi_set_s;
   logic             iready_s;

   // Byte idx of a word, MSB first.
   function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
      case (i)
         2'd0:    return w[31:24];
         2'd1:    return w[23:16];
         2'd2:    return w[15:8];
         2'd3:    return w[7:0];
         default: return 8'h00;
      endcase
   endfunction

   // Byte presented on odata while in a given state.
   function automatic logic [7:0] out_byte(input state_t st, input logic [31:0] w,
                                           input logic [1:0] i);
      case (st)
         ST_DATA:   return sel_byte(w, i);
         ST_STUFF:  return 8'h00;
         ST_EOI_FF: return 8'hFF;
         ST_EOI_D9: return 8'hD9;
         default:   return 8'h00;
      endcase
   endfunction

   assign cur_s       = sel_byte(wbuf_r, idx_r);
   assign hs_s        = ovalid_r && oready;
   assign stuff_now_s = STUFF_EN && (cur_s == 8'hFF);

   // The last output of a word: a non-FF (or unstuffed) byte 3, or the 00 after byte 3.
   assign final_hs_s  = hs_s && (idx_r == 2'd3) &&
                        (((state_r == ST_DATA) && !stuff_now_s) || (state_r == ST_STUFF));

   // Combinational path from oready lets a new word land with zero bubbles.
   assign iready_s    = !eoi_pend_r && ((state_r == ST_IDLE) || final_hs_s);
   assign accept_s    = ivalid && iready_s;
   assign eoi_set_s   = ieoi && iready_s;
   assign eoi_any_s   = eoi_pend_r || eoi_set_s;
   assign wbuf_nxt_s  = accept_s ? idata : wbuf_r;

   // Where to go after the last byte of a word: next word, pending marker, or idle.
   assign end_state_s = accept_s ? ST_DATA : (eoi_any_s ? ST_EOI_FF : ST_IDLE);

   // Next-state logic for the byte sequencer.
   always_comb begin
      state_nxt_s    = state_r;
      idx_nxt_s      = idx_r;
      eoi_pend_nxt_s = eoi_any_s;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_DATA;
               idx_nxt_s   = 2'd0;
            end else if (eoi_set_s) begin
               state_nxt_s = ST_EOI_FF;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (hs_s) begin
               if (stuff_now_s) begin
                  state_nxt_s = ST_STUFF;
               end else if (idx_r == 2'd3) begin
                  state_nxt_s = end_state_s;
                  idx_nxt_s   = 2'd0;
               end else begin
                  idx_nxt_s   = idx_r + 2'd1;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_STUFF: begin
            if (hs_s) begin
               if (idx_r == 2'd3) begin
                  state_nxt_s = end_state_s;
                  idx_nxt_s   = 2'd0;
               end else begin
                  state_nxt_s = ST_DATA;
                  idx_nxt_s   = idx_r + 2'd1;
               end
            end else begin
               state_nxt_s = ST_STUFF;
            end
         end
         ST_EOI_FF: begin
            if (hs_s) begin
               state_nxt_s = ST_EOI_D9;
            end else begin
               state_nxt_s = ST_EOI_FF;
            end
         end
         ST_EOI_D9: begin
            if (hs_s) begin
               state_nxt_s    = ST_IDLE;
               eoi_pend_nxt_s = 1'b0;
            end else begin
               state_nxt_s = ST_EOI_D9;
            end
         end
         default: begin
            state_nxt_s    = ST_IDLE;
            idx_nxt_s      = 2'd0;
            eoi_pend_nxt_s = 1'b0;
         end
      endcase
   end

   // Sequencer state and holding register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         wbuf_r     <= 32'h0000_0000;
         idx_r      <= 2'd0;
         eoi_pend_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wbuf_r     <= wbuf_nxt_s;
         idx_r      <= idx_nxt_s;
         eoi_pend_r <= eoi_pend_nxt_s;
      end
   end

   // Output register: decoded from the next state so odata/olast stay put while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovalid_r <= 1'b0;
         odata_r  <= 8'h00;
         olast_r  <= 1'b0;
      end else begin
         ovalid_r <= (state_nxt_s != ST_IDLE);
         odata_r  <= out_byte(state_nxt_s, wbuf_nxt_s, idx_nxt_s);
         olast_r  <= (state_nxt_s == ST_EOI_D9);
      end
   end

   // Emitted-byte counter, includes stuffed and marker bytes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nbytes_r <= {CNT_W{1'b0}};
      end else if (hs_s) begin
         nbytes_r <= nbytes_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         nbytes_r <= nbytes_r;
      end
   end

   assign iready = iready_s;
   assign ovalid = ovalid_r;
   assign odata  = odata_r;
   assign olast  = olast_r;
   assign nbytes = nbytes_r;

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// -----------------------------------------------------------------------------
// tb_jpeg_byte_stuffer
//   Scoreboard bench: directed stimulus pushes hand-computed expected bytes,
//   monitors pop and compare on every output handshake. A second instance
//   with stuffing disabled covers the raw pass-through mode.
// -----------------------------------------------------------------------------
module tb_jpeg_byte_stuffer;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        ivalid;
   logic [31:0] idata;
   logic        iready;
   logic        ieoi;
   logic        ovalid;
   logic [7:0]  odata;
   logic        oready;
   logic        olast;
   logic [31:0] nbytes;

   logic        ivalid_raw;
   logic [31:0] idata_raw;
   logic        iready_raw;
   logic        ovalid_raw;
   logic [7:0]  odata_raw;
   logic        olast_raw;
   logic [31:0] nbytes_raw;

   exp_t q[$];
   exp_t qr[$];
   int   n_cmp;
   int   n_err;
   int   tb_nb;

   jpeg_byte_stuffer #(.STUFF_EN(1'b1), .CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .ivalid(ivalid), .idata(idata), .iready(iready),
      .ieoi(ieoi), .ovalid(ovalid), .odata(odata), .oready(oready),
      .olast(olast), .nbytes(nbytes)
   );

   jpeg_byte_stuffer #(.STUFF_EN(1'b0), .CNT_W(32)) u_raw (
      .clk(clk), .rst(rst), .ivalid(ivalid_raw), .idata(idata_raw), .iready(iready_raw),
      .ieoi(1'b0), .ovalid(ovalid_raw), .odata(odata_raw), .oready(oready),
      .olast(olast_raw), .nbytes(nbytes_raw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expb(input logic [7:0] d, input logic l);
      exp_t e;
      e.d = d;
      e.l = l;
      q.push_back(e);
      tb_nb++;
   endtask

   // Main monitor: compare on handshake, and check hold while stalled.
   initial begin
      logic       stall_prev;
      logic [7:0] held_d;
      logic       held_l;
      exp_t       e;
      stall_prev = 1'b0;
      held_d     = 8'h00;
      held_l     = 1'b0;
      forever begin
         @(negedge clk);
         #3;
         if (!rst) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("hold_ovalid", {63'd0, ovalid}, 64'd1);
               chk("hold_odata", {56'd0, odata}, {56'd0, held_d});
               chk("hold_olast", {63'd0, olast}, {63'd0, held_l});
            end
            if (ovalid && oready) begin
               if (q.size() == 0) begin
                  chk("unexpected_byte", {56'd0, odata}, 64'hDEAD);
               end else begin
                  e = q.pop_front();
                  chk("odata", {56'd0, odata}, {56'd0, e.d});
                  chk("olast", {63'd0, olast}, {63'd0, e.l});
               end
            end
            stall_prev = ovalid && !oready;
            held_d     = odata;
            held_l     = olast;
         end
      end
   end

   // Raw-mode monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (rst && ovalid_raw && oready) begin
            if (qr.size() == 0) begin
               chk("raw_unexpected", {56'd0, odata_raw}, 64'hDEAD);
            end else begin
               e = qr.pop_front();
               chk("raw_odata", {56'd0, odata_raw}, {56'd0, e.d});
            end
         end
      end
   end

   // Drive one word (optionally with ieoi) and return just after the accepting edge.
   task automatic send_word(input logic [31:0] d, input logic eoi);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      ivalid = 1'b1;
      idata  = d;
      ieoi   = eoi;
      for (int k = 0; k < 200 && !ok; k++) begin
         #4;
         ok = iready;
         @(posedge clk);
         if (!ok) @(negedge clk);
      end
      #1;
      ivalid = 1'b0;
      ieoi   = 1'b0;
      if (!ok) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && (q.size() != 0 || qr.size() != 0); k++) @(negedge clk);
      if (q.size() != 0 || qr.size() != 0) chk("drain_timeout", 64'd0, 64'd1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      tb_nb      = 0;
      rst        = 1'b0;
      ivalid     = 1'b0;
      idata      = 32'h0;
      ieoi       = 1'b0;
      oready     = 1'b1;
      ivalid_raw = 1'b0;
      idata_raw  = 32'h0;

      // Reset state
      #12;
      chk("rst_ovalid", {63'd0, ovalid}, 64'd0);
      chk("rst_odata", {56'd0, odata}, 64'd0);
      chk("rst_olast", {63'd0, olast}, 64'd0);
      chk("rst_nbytes", {32'd0, nbytes}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #3;
      chk("rst_iready", {63'd0, iready}, 64'd1);

      // 1: plain word, latency and iready on the final byte
      expb(8'h10, 1'b0); expb(8'h10, 1'b0); expb(8'h10, 1'b0); expb(8'h10, 1'b0);
      send_word(32'h10101010, 1'b0);
      @(negedge clk); #3;
      chk("t1_ovalid_n1", {63'd0, ovalid}, 64'd1);
      chk("t1_iready_n1", {63'd0, iready}, 64'd0);
      repeat (3) @(negedge clk);
      #3;
      chk("t1_iready_n4", {63'd0, iready}, 64'd1);
      drain();
      chk("t1_nbytes", {32'd0, nbytes}, 64'd4);

      // 2: stuffing, and the raw instance with the same word
      expb(8'hFF, 1'b0); expb(8'h00, 1'b0); expb(8'h00, 1'b0); expb(8'hFF, 1'b0);
      expb(8'h00, 1'b0); expb(8'hFF, 1'b0); expb(8'h00, 1'b0);
      send_word(32'hFF00FFFF, 1'b0);
      drain();
      chk("t2_nbytes", {32'd0, nbytes}, {32'd0, tb_nb[31:0]});
      qr.push_back('{d: 8'hFF, l: 1'b0});
      qr.push_back('{d: 8'h00, l: 1'b0});
      qr.push_back('{d: 8'hFF, l: 1'b0});
      qr.push_back('{d: 8'hFF, l: 1'b0});
      @(negedge clk);
      ivalid_raw = 1'b1;
      idata_raw  = 32'hFF00FFFF;
      #4;
      chk("t2_raw_iready", {63'd0, iready_raw}, 64'd1);
      @(posedge clk);
      #1;
      ivalid_raw = 1'b0;
      drain();
      chk("t2_raw_nbytes", {32'd0, nbytes_raw}, 64'd4);

      // 3: back-to-back words, no ovalid gap
      for (int i = 0; i < 4; i++) expb(8'h20, 1'b0);
      for (int i = 0; i < 4; i++) expb(8'h30, 1'b0);
      send_word(32'h20202020, 1'b0);
      fork
         send_word(32'h30303030, 1'b0);
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk); #3;
               chk("t3_no_gap", {63'd0, ovalid}, 64'd1);
            end
         end
      join
      drain();

      // 4: backpressure pattern 1,0,0,1,0,1,1
      begin
         logic [6:0] pat;
         pat = 7'b1001011;
         expb(8'hA0, 1'b0); expb(8'hB0, 1'b0); expb(8'hC0, 1'b0); expb(8'hD0, 1'b0);
         @(negedge clk);
         oready = 1'b0;
         send_word(32'hA0B0C0D0, 1'b0);
         for (int i = 6; i >= 0; i--) begin
            @(negedge clk);
            oready = pat[i];
         end
         @(negedge clk);
         oready = 1'b1;
         drain();
      end

      // 5: ieoi with a word, then ieoi alone in IDLE
      for (int i = 0; i < 4; i++) expb(8'h11, 1'b0);
      expb(8'hFF, 1'b0);
      expb(8'hD9, 1'b1);
      send_word(32'h11111111, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #3;
         chk("t5_iready_low", {63'd0, iready}, 64'd0);
      end
      @(negedge clk); #3;
      chk("t5_iready_back", {63'd0, iready}, 64'd1);
      drain();
      expb(8'hFF, 1'b0);
      expb(8'hD9, 1'b1);
      @(negedge clk);
      ieoi = 1'b1;
      #4;
      chk("t5_eoi_iready", {63'd0, iready}, 64'd1);
      @(posedge clk);
      #1;
      ieoi = 1'b0;
      drain();
      chk("t5_nbytes", {32'd0, nbytes}, {32'd0, tb_nb[31:0]});

      // 6: reset while byte idx=2 of a word is presented
      expb(8'h05, 1'b0); expb(8'h05, 1'b0);
      send_word(32'h05050505, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      oready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("t6_ovalid", {63'd0, ovalid}, 64'd0);
      chk("t6_nbytes", {32'd0, nbytes}, 64'd0);
      chk("t6_queue_empty", {32'd0, q.size()}, 64'd0);
      q.delete();
      tb_nb = 0;
      @(negedge clk);
      rst    = 1'b1;
      oready = 1'b1;
      expb(8'h06, 1'b0); expb(8'h07, 1'b0); expb(8'h08, 1'b0); expb(8'h09, 1'b0);
      send_word(32'h06070809, 1'b0);
      drain();
      chk("t6_nbytes_after", {32'd0, nbytes}, 64'd4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
